// File: rtl/mem_access.sv
// Load/store unit for the MEM stage: one RAM access at a time, with big-endian byte lanes and a ready timeout.
// Optional build macro MEM_ACCESS_ALIGN_CHECK_EN rejects misaligned half/word accesses without touching RAM.
module mem_access #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_ex_mem,
  input  logic        MemRead_ex_mem,
  input  logic        MemWrite_ex_mem,
  input  logic [1:0]  mem_size_ex_mem,
  input  logic        mem_unsigned_ex_mem,
  input  logic [31:0] alu_out_ex_mem,
  input  logic [31:0] rt_data_ex_mem,
  output logic        ram_req,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [3:0]  ram_be,
  output logic [31:0] ram_wdata,
  input  logic        ram_ready,
  input  logic [31:0] ram_rdata,
  output logic [31:0] ram_read_data_mem,
  output logic        mem_stall,
  output logic        mem_bus_err,
  output logic        mem_misalign
);

  localparam int unsigned CNT_W = 8;
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  logic [1:0]       state, state_nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic [1:0]       size_q, off_q;
  logic             uns_q, load_q;
  logic             req_c, misalign_c, timeout_c;
  logic [3:0]       be_c;
  logic [31:0]      wdata_c, lane_shift_c, load_c;
  logic [7:0]       byte_c;
  logic [15:0]      half_c;

  assign req_c = valid_ex_mem & (MemRead_ex_mem | MemWrite_ex_mem);

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
  assign misalign_c = ((mem_size_ex_mem == 2'b01) & alu_out_ex_mem[0]) |
                      (mem_size_ex_mem[1] & (alu_out_ex_mem[1:0] != 2'b00));
`else
  assign misalign_c = 1'b0;
`endif

  // Store lane enables and replicated write data
  always_comb begin
    be_c    = 4'b1111;
    wdata_c = rt_data_ex_mem;
    case (mem_size_ex_mem)
      2'b00: begin
        be_c    = 4'b1000 >> alu_out_ex_mem[1:0];
        wdata_c = {4{rt_data_ex_mem[7:0]}};
      end
      2'b01: begin
        be_c    = alu_out_ex_mem[1] ? 4'b0011 : 4'b1100;
        wdata_c = {2{rt_data_ex_mem[15:0]}};
      end
      default: ;
    endcase
  end

  // Load lane select (offset 0 is the most significant byte) and extension
  assign lane_shift_c = ram_rdata >> {~off_q, 3'b000};
  assign byte_c       = lane_shift_c[7:0];
  assign half_c       = off_q[1] ? ram_rdata[15:0] : ram_rdata[31:16];

  always_comb begin
    case (size_q)
      2'b00:   load_c = {{24{~uns_q & byte_c[7]}}, byte_c};
      2'b01:   load_c = {{16{~uns_q & half_c[15]}}, half_c};
      default: load_c = ram_rdata;
    endcase
    if (!load_q) load_c = 32'h0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and the combinational stall
  always_comb begin
    state_nxt = state;
    mem_stall = 1'b0;
    timeout_c = 1'b0;
    case (state)
      IDLE: begin
        if (req_c) begin
          mem_stall = 1'b1;
          state_nxt = misalign_c ? DONE : ACCESS;
        end
      end
      ACCESS: begin
        mem_stall = 1'b1;
        if (ram_ready) begin
          state_nxt = DONE;
        end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
          timeout_c = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture, RAM handshake and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt          <= '0;
      size_q            <= 2'b00;
      off_q             <= 2'b00;
      uns_q             <= 1'b0;
      load_q            <= 1'b0;
      ram_req           <= 1'b0;
      ram_we            <= 1'b0;
      ram_addr          <= 32'h0;
      ram_be            <= 4'h0;
      ram_wdata         <= 32'h0;
      ram_read_data_mem <= 32'h0;
      mem_bus_err       <= 1'b0;
      mem_misalign      <= 1'b0;
    end else begin
      mem_bus_err  <= 1'b0;
      mem_misalign <= 1'b0;
      case (state)
        IDLE: begin
          if (req_c) begin
            wait_cnt  <= '0;
            size_q    <= mem_size_ex_mem;
            off_q     <= alu_out_ex_mem[1:0];
            uns_q     <= mem_unsigned_ex_mem;
            load_q    <= ~MemWrite_ex_mem;
            ram_addr  <= {alu_out_ex_mem[31:2], 2'b00};
            ram_be    <= be_c;
            ram_wdata <= wdata_c;
            ram_req   <= ~misalign_c;
            ram_we    <= MemWrite_ex_mem & ~misalign_c;
            if (misalign_c) begin
              mem_misalign      <= 1'b1;
              ram_read_data_mem <= 32'h0;
            end
          end
        end
        ACCESS: begin
          if (ram_ready) begin
            ram_req           <= 1'b0;
            ram_we            <= 1'b0;
            ram_read_data_mem <= load_c;
          end else if (timeout_c) begin
            ram_req           <= 1'b0;
            ram_we            <= 1'b0;
            mem_bus_err       <= 1'b1;
            ram_read_data_mem <= 32'h0;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 Parameter TIMEOUT, 255, ram_ready wait limit in cycles (1..255).
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 valid_ex_mem  in  1  EX/MEM slot holds a live instruction.
REQ-005 MemRead_ex_mem / MemWrite_ex_mem  in  1 each  load / store request (both high: store wins).
REQ-006 mem_size_ex_mem  in  2  00 byte, 01 half, 10 word, 11 treated as word.
REQ-007 mem_unsigned_ex_mem  in  1  zero-extend loads when high, sign-extend when low.
REQ-008 alu_out_ex_mem  in  32  byte address; rt_data_ex_mem  in  32  store data (low bits used for byte/half).
REQ-009 ram_req  out  1; ram_we  out  1; ram_addr  out  32 (bits[1:0]=0); ram_be  out  4; ram_wdata  out  32.
REQ-010 ram_ready  in  1  RAM accepts/completes the request; ram_rdata  in  32  word valid with ram_ready.
REQ-011 ram_read_data_mem  out  32  formatted load result; mem_stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM.
REQ-012 mem_bus_err  out  1  one-cycle pulse, access timed out; mem_misalign  out  1  one-cycle pulse (see Configuration).

Function
REQ-013 FSM states IDLE, ACCESS, DONE; one access at a time; big-endian byte lanes (offset 0 = bits[31:24]).
REQ-014 IDLE: valid_ex_mem & (MemRead|MemWrite) -> mem_stall=1 combinationally, register addr/data/be/we, go ACCESS next cycle; otherwise mem_stall=0, stay IDLE.
REQ-015 ACCESS: ram_req=1, ram_addr/ram_we/ram_be/ram_wdata held stable, mem_stall=1; ram_ready sampled high -> latch ram_rdata, go DONE.
REQ-016 DONE: mem_stall=0 for exactly one cycle, ram_read_data_mem valid, ram_req=0; always return to IDLE (no restart on the same still-present instruction).
REQ-017 Minimum latency with ram_ready high on first ACCESS cycle: presented cycle N, result valid and stall low in cycle N+2.
REQ-018 ram_be: word 1111; half offset 0 -> 1100, offset 2 -> 0011; byte offset k -> 1000>>k; loads also drive be.
REQ-019 ram_wdata: byte replicated to all four lanes, half replicated to both halves, word unchanged.
REQ-020 Loads: selected lane shifted to bits[7:0]/[15:0], extended per mem_unsigned_ex_mem; stores give ram_read_data_mem=0.
REQ-021 8-bit wait counter cleared on ACCESS entry, increments each ACCESS cycle with ram_ready low; reaching TIMEOUT -> go DONE, pulse mem_bus_err, ram_read_data_mem=0.
REQ-022 ram_ready in the same cycle the counter reaches TIMEOUT: completion wins, no mem_bus_err.
REQ-023 ram_ready outside ACCESS is ignored; ram_rdata outside ram_ready cycles is ignored.
REQ-024 ram_read_data_mem holds its value outside DONE until the next DONE.

Reset
REQ-025 rst_n low: immediately state IDLE, counter 0, ram_req/ram_we/mem_bus_err/mem_misalign 0, ram_addr/ram_be/ram_wdata/ram_read_data_mem 0.
REQ-026 Reset mid-ACCESS abandons the access; no pulse is generated; resumes in IDLE on the first edge after rst_n rises.

Configuration
REQ-027 Macro MEM_ACCESS_ALIGN_CHECK_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 skips ACCESS (IDLE -> DONE), no ram_req, mem_misalign pulses in DONE, result 0.
REQ-028 Macro undefined: mem_misalign tied 0; half ignores addr[0], word ignores addr[1:0]; all accesses go to RAM.

Verification
REQ-029 Word store addr 0x10, data 0xDEADBEEF, ram_ready immediate -> ram_addr 0x10, be 1111, wdata 0xDEADBEEF, stall high 2 cycles.
REQ-030 Byte load signed addr 0x13, ram_rdata 0x123456F0 -> ram_read_data_mem 0xFFFFFFF0; unsigned -> 0x000000F0; be 0001.
REQ-031 Half load unsigned addr 0x20, ram_rdata 0xABCD0000, ready after 5 cycles -> 0x0000ABCD, stall high 7 cycles.
REQ-032 ram_ready never asserted, TIMEOUT=4 -> mem_bus_err pulse after 4 ACCESS cycles, result 0, stall released.
REQ-033 rst_n low during ACCESS -> ram_req drops asynchronously, next access completes normally.
REQ-034 With MEM_ACCESS_ALIGN_CHECK_EN, word load addr 0x22 -> no ram_req, mem_misalign one pulse, result 0.
